imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction memory size in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from request accept to response valid (legal 1..15).
REQ-003 SHALL have port i_clk input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n input 1, the asynchronous active-low reset.
REQ-005 SHALL have port i_req_valid input 1, meaning a fetch request is present.
REQ-006 SHALL have port i_req_addr input 32, meaning the byte address of the fetch (the PC value).
REQ-007 SHALL have port o_req_ready output 1, meaning the block can accept a request this cycle.
REQ-008 SHALL have port o_rsp_valid output 1, meaning the response is valid.
REQ-009 SHALL have port i_rsp_ready input 1, meaning the consumer takes the response this cycle.
REQ-010 SHALL have port o_rsp_data output 32, meaning the fetched instruction word.
REQ-011 SHALL have port o_rsp_err output 1, meaning the fetch faulted.
REQ-012 SHALL have port i_wr_en input 1, meaning a memory load write.
REQ-013 SHALL have port i_wr_addr input 32, meaning the byte address of the load write (bits [1:0] ignored).
REQ-014 SHALL have port i_wr_data input 32, meaning the load write data.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP; o_req_ready = 1 only in IDLE with i_rst_n high.
REQ-016 SHALL accept a request on a rising edge with i_req_valid && o_req_ready, and SHALL hold at most one outstanding request.
REQ-017 SHALL capture data and error at the accept edge: word index i_req_addr[log2(DEPTH)+1:2], using array contents from before any same-edge write (read-before-write).
REQ-018 SHALL flag out-of-range (i_req_addr >= 4*DEPTH) as err=1, with data 32'h00000013 (NOP).
REQ-019 SHALL, on accept, go to RESP if LATENCY==1, else go to WAIT and load a down-counter with LATENCY-1.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and enter RESP when it reaches 1, so that o_rsp_valid rises exactly LATENCY edges after the accept edge.
REQ-021 SHALL, in RESP, hold o_rsp_valid=1 with o_rsp_data and o_rsp_err stable until an edge with i_rsp_ready=1, then return to IDLE.
REQ-022 SHALL NOT accept a new request on the edge that completes a response (ready is first seen in the following IDLE cycle); the minimum request period is LATENCY+1 cycles.
REQ-023 SHALL ignore i_req_valid and i_req_addr changes outside IDLE.
REQ-024 SHALL perform an i_wr_en write on any edge regardless of state; out-of-range write addresses SHALL be dropped.
REQ-025 SHALL NOT alter a pending response because of a later write to the same word.
REQ-026 SHALL drive o_rsp_data=0 and o_rsp_err=0 whenever o_rsp_valid=0.

Reset
REQ-027 SHALL, while i_rst_n=0 (asynchronously), force state IDLE, counter 0, o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0.
REQ-028 SHALL abandon any in-flight request on reset mid-operation; no response SHALL follow it.
REQ-029 SHALL NOT reset memory array contents.

Configuration
REQ-030 SHALL, with macro IMEM_ALIGN_CHECK_EN defined, treat i_req_addr[1:0]!=0 as a fault: err=1, data 32'h00000013.
REQ-031 SHALL, with IMEM_ALIGN_CHECK_EN undefined, ignore i_req_addr[1:0] and return the aligned word with err=0.

Verification
REQ-032 SHALL cover a basic fetch: LATENCY=1; load word 3 = 32'hDEADBEEF; request addr 32'h0C -> valid 1 cycle later with data DEADBEEF, err=0.
REQ-033 SHALL cover backpressure: LATENCY=3, i_rsp_ready held low 5 cycles -> valid appears 3 cycles after accept, data held stable, o_req_ready=0 until 1 cycle after the consuming edge.
REQ-034 SHALL cover out-of-range: DEPTH=256, request 32'h400 -> err=1, data 32'h00000013.
REQ-035 SHALL cover misalignment: request 32'h06 -> err=1 with IMEM_ALIGN_CHECK_EN, otherwise word 1 with err=0.
REQ-036 SHALL cover a write hazard: same-edge write of 32'h11111111 to word 0 while accepting addr 0 (old 32'h22222222) -> response 22222222; the next fetch returns 11111111.
REQ-037 SHALL cover reset in WAIT: LATENCY=4, drop i_rst_n 2 cycles after accept -> outputs zero immediately, no response after release, o_req_ready=1 next cycle.

Source files
------------

// File: rtl/imem_resp.sv
// imem_resp: single-outstanding instruction fetch responder with a loadable
// word array and a configurable fixed response latency.
// Optional feature: define IMEM_ALIGN_CHECK_EN to fault misaligned fetches.
module imem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          req_oor;
  logic          req_mis;
  logic          req_fault;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_oor;
  logic [3:0]    unused_addr_bits;

  assign req_idx = i_req_addr[AW+1:2];
  assign req_oor = |i_req_addr[31:AW+2];
  assign wr_idx  = i_wr_addr[AW+1:2];
  assign wr_oor  = |i_wr_addr[31:AW+2];

`ifdef IMEM_ALIGN_CHECK_EN
  assign req_mis = |i_req_addr[1:0];
`else
  assign req_mis = 1'b0;
`endif

  // Byte-offset bits never address the word array.
  assign unused_addr_bits = {i_req_addr[1:0], i_wr_addr[1:0]};

  assign req_fault = req_oor | req_mis;
  assign accept    = (state == IDLE) & i_req_valid;

  // Ready is visible only in IDLE and is killed combinationally by reset.
  assign o_req_ready = (state == IDLE) & i_rst_n;
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_data  = (state == RESP) ? data_q : 32'h0000_0000;
  assign o_rsp_err   = (state == RESP) ? err_q  : 1'b0;

  // Next-state and latency counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = cnt;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = cnt - 4'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset abandons any in-flight fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the response at the accept edge (array value before any same-edge write).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= 32'h0000_0000;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= req_fault ? NOP : mem[req_idx];
      err_q  <= req_fault;
    end else begin
      data_q <= data_q;
      err_q  <= err_q;
    end
  end

  // Load-port writes happen in any state; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !wr_oor) begin
      mem[wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// Bench for imem_resp: three instances (LATENCY 1, 3, 4), a vector table,
// hand sequences for hazards/backpressure/reset, and randomized fetches
// checked against an array-based reference model.
module tb_imem_resp;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_data  [3];
  logic        rsp_err   [3];
  logic        wr_en     [3];
  logic [31:0] wr_addr   [3];
  logic [31:0] wr_data   [3];

  int vectors     = 0;
  int miscompares = 0;
  int lat_exp [3] = '{1, 3, 4};
  logic [31:0] mem_m [3][256];

  always #5 clk = ~clk;

  imem_resp #(.DEPTH(256), .LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_req_valid(req_valid[0]), .i_req_addr(req_addr[0]),
    .o_req_ready(req_ready[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0]), .i_wr_en(wr_en[0]),
    .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]));

  imem_resp #(.DEPTH(256), .LATENCY(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_req_valid(req_valid[1]), .i_req_addr(req_addr[1]),
    .o_req_ready(req_ready[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1]), .i_wr_en(wr_en[1]),
    .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]));

  imem_resp #(.DEPTH(256), .LATENCY(4)) u_lat4 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_req_valid(req_valid[2]), .i_req_addr(req_addr[2]),
    .o_req_ready(req_ready[2]), .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]),
    .o_rsp_data(rsp_data[2]), .o_rsp_err(rsp_err[2]), .i_wr_en(wr_en[2]),
    .i_wr_addr(wr_addr[2]), .i_wr_data(wr_data[2]));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what a fetch of address a must return.
  function automatic logic [32:0] ref_fetch(input int k, input logic [31:0] a);
    if (a >= 32'h0000_0400) return {1'b1, 32'h0000_0013};
`ifdef IMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return {1'b1, 32'h0000_0013};
`endif
    return {1'b0, mem_m[k][a / 4]};
  endfunction

  task automatic mwrite(input int k, input logic [31:0] wa, input logic [31:0] wd);
    if (wa < 32'h0000_0400) mem_m[k][wa / 4] = wd;
  endtask

  task automatic load(input int k, input logic [31:0] wa, input logic [31:0] wd);
    wr_en[k] = 1'b1; wr_addr[k] = wa; wr_data[k] = wd;
    mwrite(k, wa, wd);
    @(posedge clk); #1;
    wr_en[k] = 1'b0;
  endtask

  // One complete fetch: optional write on the accept edge, optional later
  // write to the fetched word, and `stall` cycles of backpressure.
  task automatic do_fetch(input int k, input logic [31:0] addr, input int stall,
                          input bit swe, input logic [31:0] swa, input logic [31:0] swd,
                          input bit lwe, input logic [31:0] lwd,
                          output logic [31:0] d, output logic e);
    logic [32:0] exp;
    int n;
    int lat;
    d = 32'h0; e = 1'b0;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 64'(req_ready[k]), 64'd1);
    exp = ref_fetch(k, addr);
    req_valid[k] = 1'b1; req_addr[k] = addr;
    wr_en[k] = swe; wr_addr[k] = swa; wr_data[k] = swd;
    if (swe) mwrite(k, swa, swd);
    @(posedge clk); #1;
    // Request lines now carry junk that must be ignored outside IDLE.
    req_valid[k] = 1'b1; req_addr[k] = $urandom;
    wr_en[k] = lwe; wr_addr[k] = {addr[31:2], 2'b00}; wr_data[k] = lwd;
    if (lwe) mwrite(k, {addr[31:2], 2'b00}, lwd);
    lat = 1;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin
      chk("wait_outputs_zero", {31'h0, rsp_data[k], rsp_err[k], req_ready[k]}, 64'd0);
      @(posedge clk); #1; wr_en[k] = 1'b0; lat++;
    end
    chk("latency", 64'(lat), 64'(lat_exp[k]));
    d = rsp_data[k]; e = rsp_err[k];
    chk("rsp_word", {31'h0, e, d}, {31'h0, exp});
    chk("rsp_busy", 64'(req_ready[k]), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1; wr_en[k] = 1'b0;
      chk("rsp_hold", {29'h0, rsp_valid[k], rsp_err[k], rsp_data[k], req_ready[k]},
          {29'h0, 1'b1, exp[32], exp[31:0], 1'b0});
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0; wr_en[k] = 1'b0; req_valid[k] = 1'b0;
    chk("after_consume", {29'h0, req_ready[k], rsp_valid[k], rsp_err[k], rsp_data[k]},
        {29'h0, 1'b1, 1'b0, 1'b0, 32'h0});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic [31:0] d;
    logic e;
    logic [31:0] a;
    logic [31:0] v;

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = 32'h0; rsp_ready[k] = 1'b0;
      wr_en[k] = 1'b0; wr_addr[k] = 32'h0; wr_data[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk("reset_outputs", {29'h0, req_ready[k], rsp_valid[k], rsp_err[k], rsp_data[k]}, 64'd0);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("ready_after_reset", 64'(req_ready[k]), 64'd1);

    // Fill every word of every instance.
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 3; k++) begin
        v = $urandom;
        wr_en[k] = 1'b1; wr_addr[k] = i * 4; wr_data[k] = v;
        mwrite(k, i * 4, v);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) wr_en[k] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      load(k, 32'h0000_000C, 32'hDEAD_BEEF);
      load(k, 32'h0000_0000, 32'h2222_2222);
      load(k, 32'h0000_0004, 32'hA5A5_0001);
      load(k, 32'h0000_03FC, 32'hCAFE_F00D);
    end

    tbl[0] = '{32'h0000_000C, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
`ifdef IMEM_ALIGN_CHECK_EN
    tbl[2] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
`else
    tbl[2] = '{32'h0000_0006, 32'hA5A5_0001, 1'b0};
`endif
    tbl[3] = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
    tbl[5] = '{32'h0000_0004, 32'hA5A5_0001, 1'b0};

    for (int i = 0; i < 6; i++) begin
      do_fetch(0, tbl[i].addr, i % 3, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, d, e);
      chk("table_data", {32'h0, d}, {32'h0, tbl[i].data});
      chk("table_err", 64'(e), 64'(tbl[i].err));
    end

    // Out-of-range write must not alias onto word 0.
    load(0, 32'h0000_0400, 32'h0000_0BAD);
    do_fetch(0, 32'h0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, d, e);
    chk("oor_write_dropped", {32'h0, d}, {32'h0, 32'h2222_2222});

    // Same-edge write hazard: old word returned, new word on next fetch.
    do_fetch(0, 32'h0, 0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 32'h0, d, e);
    chk("hazard_old", {32'h0, d}, {32'h0, 32'h2222_2222});
    do_fetch(0, 32'h0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, d, e);
    chk("hazard_new", {32'h0, d}, {32'h0, 32'h1111_1111});

    // Backpressure on the LATENCY=3 instance, with a later write to the pending word.
    do_fetch(1, 32'h0000_000C, 5, 1'b0, 32'h0, 32'h0, 1'b1, 32'h7777_7777, d, e);
    chk("backpressure_data", {31'h0, e, d}, {31'h0, 1'b0, 32'hDEAD_BEEF});

    // Reset while waiting on the LATENCY=4 instance.
    req_valid[2] = 1'b1; req_addr[2] = 32'h0000_0010;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    chk("reset_in_wait", {29'h0, req_ready[2], rsp_valid[2], rsp_err[2], rsp_data[2]}, 64'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    #1;
    chk("ready_after_release", 64'(req_ready[2]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", {62'h0, rsp_valid[2], req_ready[2]}, 64'd1);
    end
    do_fetch(2, 32'h0000_000C, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, d, e);

    // Randomized fetches against the reference model.
    for (int it = 0; it < 60; it++) begin
      int k;
      int sel;
      k = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      if (sel < 2)       a = $urandom_range(0, 255) * 4;
      else if (sel == 2) a = $urandom_range(0, 1023);
      else               a = $urandom;
      do_fetch(k, a, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), $urandom_range(0, 2047), $urandom,
               1'($urandom_range(0, 1)), $urandom, d, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
